// File: rtl/hw5_seq_pkg.sv
// hw5_seq_pkg: shared state type and default parameters for hw5_load_sequencer
package hw5_seq_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, HOLD, DONE} state_t;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_HOLD_CYCLES = 8;
endpackage

// File: rtl/hw5_rr_arbiter.sv
// hw5_rr_arbiter: two-request arbiter; round-robin with HW5_SEQ_RR_EN defined, else fixed priority to requester 0
module hw5_rr_arbiter (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic grant_en,
  output logic sel
);
`ifdef HW5_SEQ_RR_EN
  logic last;
  // on a tie the requester not granted last wins
  always_comb sel = (req0 && req1) ? !last : req1;
  // remember the most recent grant; reset points at requester 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (grant_en) last <= sel;
`else
  logic unused_ok;
  // requester 0 always wins
  always_comb sel = !req0 && req1;
  assign unused_ok = &{1'b0, clk, rst_n, grant_en};
`endif
endmodule

// File: rtl/hw5_load_sequencer.sv
// hw5_load_sequencer: arbitrates two load requesters onto HW5 Load/Din with a fixed hold window (HW5_SEQ_RR_EN selects round-robin)
module hw5_load_sequencer
  import hw5_seq_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [DATA_W-1:0] din0,
  input  logic              req1,
  input  logic [DATA_W-1:0] din1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              load,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic arb, sel;
  assign arb = (state == IDLE || state == DONE) && (req0 || req1);
  hw5_rr_arbiter u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req0(req0),
    .req1(req1),
    .grant_en(arb),
    .sel(sel)
  );
  // next state and hold counter; counter saturates at zero
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (state == LOAD) begin
      state_nx = HOLD;
      cnt_nx = CW'(HOLD_CYCLES - 1);
    end else if (state == HOLD) begin
      state_nx = (cnt == '0) ? DONE : HOLD;
      cnt_nx = (cnt == '0) ? cnt : cnt - 1'b1;
    end else begin
      state_nx = arb ? LOAD : IDLE;
    end
  end
  // state, counter and registered outputs derived from the next state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      load <= 1'b0;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      dout <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      load <= state_nx == LOAD;
      gnt0 <= arb && !sel;
      gnt1 <= arb && sel;
      busy <= state_nx != IDLE;
      done <= state_nx == DONE;
      if (arb) dout <= sel ? din1 : din0;
    end
endmodule

// File: tb/tb_hw5_load_sequencer.sv
// tb_hw5_load_sequencer: directed vector table, hand-written corner cases and randomized model check
module tb_hw5_load_sequencer;
  localparam int H = 8;
`ifdef HW5_SEQ_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 0, rst_n = 1, req0 = 0, req1 = 0;
  logic [3:0] din0 = 0, din1 = 0, dout;
  logic gnt0, gnt1, load, busy, done;
  logic b_rst_n = 1, b_req0 = 0, b_req1 = 0;
  logic [3:0] b_din0 = 0, b_din1 = 0, b_dout;
  logic b_gnt0, b_gnt1, b_load, b_busy, b_done;
  int checks = 0, failures = 0;

  hw5_load_sequencer #(.DATA_W(4), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .din0(din0), .req1(req1), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .load(load), .dout(dout), .busy(busy), .done(done));

  hw5_load_sequencer #(.DATA_W(4), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(b_rst_n), .req0(b_req0), .din0(b_din0), .req1(b_req1), .din1(b_din1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .load(b_load), .dout(b_dout), .busy(b_busy), .done(b_done));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input bit ld, input bit g0, input bit g1,
                         input logic [3:0] d, input bit b, input bit dn);
    chk({nm, "_load"}, 32'(load), 32'(ld));
    chk({nm, "_gnt0"}, 32'(gnt0), 32'(g0));
    chk({nm, "_gnt1"}, 32'(gnt1), 32'(g1));
    chk({nm, "_dout"}, 32'(dout), 32'(d));
    chk({nm, "_busy"}, 32'(busy), 32'(b));
    chk({nm, "_done"}, 32'(done), 32'(dn));
  endtask

  // transaction-timeline model: ph counts cycles since the grant (-1 = idle)
  int ph = -1;
  bit m_last = 1'b1, m_win = 1'b0;
  logic [3:0] m_dout = 0;
  function automatic void m_reset();
    ph = -1;
    m_last = 1'b1;
    m_dout = 0;
  endfunction
  function automatic void m_edge(bit r0, bit r1, logic [3:0] d0, logic [3:0] d1);
    bool_arb: begin
      if ((ph < 0 || ph == H + 1) && (r0 || r1)) begin
        m_win = (r0 && r1) ? (RR ? !m_last : 1'b0) : r1;
        m_last = m_win;
        m_dout = m_win ? d1 : d0;
        ph = 0;
      end else if (ph < 0 || ph == H + 1) ph = -1;
      else ph++;
    end
  endfunction

  typedef struct {
    bit rst, r0, r1;
    logic [3:0] d0, d1;
    int n;
    bit ld, g0, g1;
    logic [3:0] dout;
    bit busy, done;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(bit rst, bit r0, bit r1, logic [3:0] d0, logic [3:0] d1, int n,
                             bit ld, bit g0, bit g1, logic [3:0] dout, bit busy, bit done);
    vec_t x;
    x.rst = rst; x.r0 = r0; x.r1 = r1; x.d0 = d0; x.d1 = d1; x.n = n;
    x.ld = ld; x.g0 = g0; x.g1 = g1; x.dout = dout; x.busy = busy; x.done = done;
    return x;
  endfunction

  initial begin
    bit g2;
    int t, l1, l2;
    logic [3:0] d2nd;
    g2 = RR;
    // reset, then a single request from requester 0
    tbl.push_back(v(1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 4, 0, 1, 1, 1, 0, 4, 1, 0));
    tbl.push_back(v(0, 0, 0, 4, 0, H, 0, 0, 0, 4, 1, 0));
    tbl.push_back(v(0, 0, 0, 4, 0, 1, 0, 0, 0, 4, 1, 1));
    tbl.push_back(v(0, 0, 0, 4, 0, 2, 0, 0, 0, 4, 0, 0));
    // request from requester 1 arriving during HOLD waits for DONE
    tbl.push_back(v(0, 1, 0, 5, 0, 1, 1, 1, 0, 5, 1, 0));
    tbl.push_back(v(0, 0, 0, 5, 0, 2, 0, 0, 0, 5, 1, 0));
    tbl.push_back(v(0, 0, 1, 5, 7, H - 2, 0, 0, 0, 5, 1, 0));
    tbl.push_back(v(0, 0, 1, 5, 7, 1, 0, 0, 0, 5, 1, 1));
    tbl.push_back(v(0, 0, 1, 5, 7, 1, 1, 0, 1, 7, 1, 0));
    tbl.push_back(v(0, 0, 0, 5, 7, H, 0, 0, 0, 7, 1, 0));
    tbl.push_back(v(0, 0, 0, 5, 7, 1, 0, 0, 0, 7, 1, 1));
    tbl.push_back(v(0, 0, 0, 5, 7, 1, 0, 0, 0, 7, 0, 0));
    // tie with both requests held: DONE goes straight to LOAD
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 3, 9, 1, 1, 1, 0, 3, 1, 0));
    tbl.push_back(v(0, 1, 1, 3, 9, H, 0, 0, 0, 3, 1, 0));
    tbl.push_back(v(0, 1, 1, 3, 9, 1, 0, 0, 0, 3, 1, 1));
    tbl.push_back(v(0, 1, 1, 3, 9, 1, 1, !g2, g2, g2 ? 4'd9 : 4'd3, 1, 0));
    tbl.push_back(v(0, 1, 1, 3, 9, H, 0, 0, 0, g2 ? 4'd9 : 4'd3, 1, 0));
    tbl.push_back(v(0, 1, 1, 3, 9, 1, 0, 0, 0, g2 ? 4'd9 : 4'd3, 1, 1));
    tbl.push_back(v(0, 1, 1, 3, 9, 1, 1, 1, 0, 3, 1, 0));
    #2 rst_n = 0; b_rst_n = 0;
    #2 b_rst_n = 1;
    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = !tbl[i].rst; req0 = tbl[i].r0; req1 = tbl[i].r1; din0 = tbl[i].d0; din1 = tbl[i].d1;
      for (int k = 0; k < tbl[i].n; k++) begin
        @(posedge clk);
        #1 chk_all($sformatf("vec%0d", i), tbl[i].ld, tbl[i].g0, tbl[i].g1, tbl[i].dout, tbl[i].busy, tbl[i].done);
      end
    end
    // reset three cycles into HOLD clears outputs without a clock edge
    req1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1 chk_all("regrant", 1, 1, 0, 3, 1, 0);
    // HOLD_CYCLES=1 instance: back-to-back loads three cycles apart
    @(negedge clk);
    b_req0 = 1; b_req1 = 1; b_din0 = 2; b_din1 = 6;
    t = 0; l1 = -1; l2 = -100; d2nd = 0;
    while (t < 40 && l2 < 0) begin
      @(posedge clk);
      #1;
      if (b_load) begin
        if (l1 < 0) l1 = t;
        else begin
          l2 = t;
          d2nd = b_dout;
        end
      end
      if (b_gnt0) b_req0 = 0;
      if (b_gnt1) b_req1 = 0;
      t++;
    end
    chk("h1_spacing", 32'(l2 - l1), 32'd3);
    chk("h1_second_dout", 32'(d2nd), 32'd6);
    // randomized traffic against the timeline model
    @(negedge clk);
    rst_n = 0; req0 = 0; req1 = 0;
    @(negedge clk);
    rst_n = 1;
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (gnt0 || (req0 && $urandom_range(0, 40) == 0)) req0 = 0;
      else if (!req0 && $urandom_range(0, 3) == 0) begin
        req0 = 1;
        din0 = 4'($urandom);
      end
      if (gnt1 || (req1 && $urandom_range(0, 40) == 0)) req1 = 0;
      else if (!req1 && $urandom_range(0, 3) == 0) begin
        req1 = 1;
        din1 = 4'($urandom);
      end
      @(posedge clk);
      m_edge(req0, req1, din0, din1);
      #1 chk_all("rand", ph == 0, ph == 0 && !m_win, ph == 0 && m_win, m_dout, ph >= 0, ph == H + 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
